// File: rtl/div_iter_if.sv
// Handshake/data bundle between the E-stage issue logic and the iterative divider.
interface div_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic               cancel_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               stall_div_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, cancel_i, opdata1_i, opdata2_i,
    input  stall_div_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, cancel_i, opdata1_i, opdata2_i,
    output stall_div_o, ready_o, result_o
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU; result {remainder, quotient} with one-cycle ready pulse.
// Optional DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle with a zero result.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_iter_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_END} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]       t;
  logic                 ge;
  logic [WIDTH-1:0]     r_nx, q_nx, abs_a, abs_b, quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    b_d       = b_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = result_q;

    // Partial remainder may reach 2^WIDTH-1, so the trial value needs WIDTH+1 bits.
    t       = {r_q, q_q[WIDTH-1]};
    ge      = (t >= {1'b0, b_q});
    r_nx    = ge ? (t[WIDTH-1:0] - b_q) : t[WIDTH-1:0];
    q_nx    = {q_q[WIDTH-2:0], ge};
    quo_fix = neg_quo_q ? -q_nx : q_nx;
    rem_fix = neg_rem_q ? -r_nx : r_nx;

    abs_a = (bus.signed_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs_b = (bus.signed_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
`ifdef DIV_ZERO_FAST_EN
          if (bus.opdata2_i == '0) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = '0;
          end else begin
`else
          begin
`endif
            state_d   = S_ON;
            cnt_d     = '0;
            r_d       = '0;
            q_d       = abs_a;
            b_d       = abs_b;
            neg_quo_d = bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            neg_rem_d = bus.signed_i & bus.opdata1_i[WIDTH-1];
          end
        end
      end
      S_ON: begin
        r_d   = r_nx;
        q_d   = q_nx;
        cnt_d = cnt_q + 1'b1;
        // Final iteration loads the fixed-up result so it is valid throughout END.
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.cancel_i) begin
      state_d  = S_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      b_q       <= b_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.result_o    = result_q;
  assign bus.stall_div_o = bus.start_i & ~ready_q & ~bus.cancel_i;
endmodule
